// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM states and ALU op codes for the multicycle core.
// Also provides the opcode-to-ALU-op mapping used in EXEC.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_ADDI = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_BEQ  = 4'h8,
    OP_JMP  = 4'h9,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_EQ
  } alu_op_t;

  function automatic alu_op_t alu_sel(
    input logic [3:0] op
  );
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_BEQ:  return ALU_EQ;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: add, sub, and, or, equality.
// Arithmetic wraps at DATA_W; EQ returns 1 in bit 0.
module mc_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_EQ:  y = {{(DATA_W-1){1'b0}}, a == b};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle 16-bit core: FETCH/DECODE/EXEC/MEM/WB/HALT FSM,
// 8-entry register file (r0 hardwired to zero) and PC.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8,
  parameter int PC_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [8:0]        dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              halted
);

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] r;
  logic [DATA_W-1:0] regs [REG_CNT];

  logic [3:0]        op;
  logic [2:0]        ra;
  logic [2:0]        rb;
  logic [DATA_W-1:0] imm_x;
  logic [PC_W-1:0]   off_x;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   br_tgt;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;

  assign op     = ir[15:12];
  assign ra     = ir[11:9];
  assign rb     = ir[8:6];
  assign imm_x  = {{(DATA_W-9){ir[8]}}, ir[8:0]};
  assign off_x  = {{(PC_W-6){ir[5]}}, ir[5:0]};
  assign pc_inc = pc + PC_W'(1);
  assign br_tgt = pc_inc + off_x;

  // r0 reads as zero regardless of array contents
  assign rd_a  = (ra == 3'd0) ? '0 : regs[ra];
  assign rd_b  = (rb == 3'd0) ? '0 : regs[rb];
  assign alu_b = (op == OP_ADDI) ? imm_x : b;

  assign imem_addr  = pc;
  assign dmem_addr  = ir[8:0];
  assign dmem_wdata = a;

  mc_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op(alu_sel(op)),
    .a (a),
    .b (alu_b),
    .y (alu_y)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      r        <= '0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      halted   <= 1'b0;
      for (int i = 0; i < REG_CNT; i++)
        regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          ir    <= imem_data;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a     <= rd_a;
          b     <= rd_b;
          state <= S_EXEC;
        end
        S_EXEC: begin
          r <= alu_y;
          case (op)
            OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_ADDI: begin
              state <= S_WB;
            end
            OP_LD: begin
              dmem_req <= 1'b1;
              dmem_we  <= 1'b0;
              state    <= S_MEM;
            end
            OP_ST: begin
              dmem_req <= 1'b1;
              dmem_we  <= 1'b1;
              pc       <= pc_inc;
              state    <= S_MEM;
            end
            OP_BEQ: begin
              pc    <= alu_y[0] ? br_tgt : pc_inc;
              state <= S_FETCH;
            end
            OP_JMP: begin
              pc    <= PC_W'(ir[8:0]);
              state <= S_FETCH;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              pc    <= pc_inc;
              state <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (dmem_we) begin
              state <= S_FETCH;
            end else begin
              r     <= dmem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (ra != 3'd0)
            regs[ra] <= r;
          pc    <= pc_inc;
          state <= S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: small programs in a ROM model,
// a data-memory model with programmable wait states.
module tb_multicycle_cpu;

  logic        clk;
  logic        rst;
  logic [8:0]  imem_addr;
  logic [15:0] imem_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [8:0]  dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ready;
  logic        halted;

  logic [15:0] rom [512];
  logic [8:0]  trace [64];

  int          n_checks;
  int          n_fail;
  int          wait_cfg;
  int          wcnt;
  int          req_cnt;
  int          bad;
  int          nc;
  logic [8:0]  exp_addr;
  logic        exp_we;
  logic [15:0] exp_wdata;
  logic [15:0] last_wdata;

  multicycle_cpu u_dut (
    .clk       (clk),
    .rst       (rst),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data  = rom[imem_addr];
  assign dmem_ready = dmem_req && (wcnt == wait_cfg);

  always @(posedge clk or negedge rst) begin
    if (!rst)
      wcnt <= 0;
    else if (dmem_req && !dmem_ready)
      wcnt <= wcnt + 1;
    else
      wcnt <= 0;
  end

  always @(negedge clk) begin
    if (rst && dmem_req) begin
      req_cnt++;
      if (dmem_addr != exp_addr || dmem_we != exp_we)
        bad++;
      if (exp_we && dmem_wdata != exp_wdata)
        bad++;
      if (dmem_ready && dmem_we)
        last_wdata = dmem_wdata;
    end
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 512; i++)
      rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req_cnt    = 0;
    bad        = 0;
    last_wdata = 16'hDEAD;
    rst = 1'b1;
  endtask

  // Sample once per cycle at the falling edge; stop early on halt.
  task automatic run(input int maxc, output int ncyc);
    ncyc = maxc;
    trace[0] = imem_addr;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (c < 64)
        trace[c] = imem_addr;
      if (halted) begin
        ncyc = c;
        break;
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    wait_cfg   = 0;
    dmem_rdata = 16'h0000;
    exp_addr   = '0;
    exp_we     = 1'b0;
    exp_wdata  = '0;
    rst        = 1'b0;
    clear_rom();
    rom[0] = 16'h5205;
    #2;
    check("rst_pc", 32'(imem_addr), 32'h0);
    check("rst_req", 32'(dmem_req), 32'h0);
    check("rst_we", 32'(dmem_we), 32'h0);
    check("rst_halt", 32'(halted), 32'h0);
    @(negedge clk);

    // ADDI/ADDI/ADD/HALT
    clear_rom();
    rom[0] = 16'h5205;
    rom[1] = 16'h55FD;
    rom[2] = 16'h1280;
    rom[3] = 16'hF000;
    do_reset();
    run(40, nc);
    check("alu_cycles", 32'(nc), 32'd15);
    check("alu_r1", 32'(u_dut.regs[1]), 32'h0002);
    check("alu_r2", 32'(u_dut.regs[2]), 32'hFFFD);
    check("alu_halted", 32'(halted), 32'h1);
    check("alu_pc4", 32'(trace[4]), 32'h1);
    check("alu_pc12", 32'(trace[12]), 32'h3);

    // store with 3 wait cycles
    clear_rom();
    rom[0] = 16'h5255;
    rom[1] = 16'h7210;
    rom[2] = 16'hF000;
    wait_cfg  = 3;
    exp_addr  = 9'h010;
    exp_we    = 1'b1;
    exp_wdata = 16'h0055;
    do_reset();
    run(40, nc);
    check("st_req_cycles", 32'(req_cnt), 32'd4);
    check("st_stable", 32'(bad), 32'd0);
    check("st_wdata", 32'(last_wdata), 32'h0055);
    check("st_cycles", 32'(nc), 32'd14);
    check("st_next_pc", 32'(trace[11]), 32'h2);

    // load, ready on first MEM cycle
    clear_rom();
    rom[0] = 16'h6620;
    rom[1] = 16'hF000;
    wait_cfg   = 0;
    dmem_rdata = 16'hBEEF;
    exp_addr   = 9'h020;
    exp_we     = 1'b0;
    do_reset();
    run(40, nc);
    check("ld_r3", 32'(u_dut.regs[3]), 32'hBEEF);
    check("ld_next_pc", 32'(trace[5]), 32'h1);
    check("ld_cycles", 32'(nc), 32'd8);
    check("ld_req_cycles", 32'(req_cnt), 32'd1);
    check("ld_stable", 32'(bad), 32'd0);

    // BEQ taken backwards
    clear_rom();
    rom[0] = 16'h5201;
    rom[1] = 16'h5402;
    rom[2] = 16'h9005;
    rom[4] = 16'hF000;
    rom[5] = 16'h827E;
    do_reset();
    run(40, nc);
    check("beq_t_at5", 32'(trace[11]), 32'h5);
    check("beq_t_tgt", 32'(trace[14]), 32'h4);
    check("beq_t_cycles", 32'(nc), 32'd17);

    // BEQ not taken
    rom[4] = 16'h0000;
    rom[5] = 16'h82BE;
    rom[6] = 16'hF000;
    do_reset();
    run(40, nc);
    check("beq_nt_tgt", 32'(trace[14]), 32'h6);
    check("beq_nt_cycles", 32'(nc), 32'd17);

    // JMP to top of space, then wrap
    clear_rom();
    rom[0]   = 16'h91FF;
    rom[511] = 16'h0000;
    do_reset();
    run(9, nc);
    check("jmp_tgt", 32'(trace[3]), 32'h1FF);
    check("jmp_wrap", 32'(trace[6]), 32'h0);
    check("jmp_nohalt", 32'(halted), 32'h0);

    // r0 stays zero
    clear_rom();
    rom[0] = 16'h5007;
    rom[1] = 16'h7030;
    rom[2] = 16'hF000;
    exp_addr  = 9'h030;
    exp_we    = 1'b1;
    exp_wdata = 16'h0000;
    do_reset();
    run(40, nc);
    check("r0_read", 32'(last_wdata), 32'h0000);
    check("r0_stable", 32'(bad), 32'd0);
    check("r0_cycles", 32'(nc), 32'd11);

    // undefined opcode acts as NOP
    clear_rom();
    rom[0] = 16'hC323;
    rom[1] = 16'hF000;
    do_reset();
    run(40, nc);
    check("undef_pc", 32'(trace[3]), 32'h1);
    check("undef_cycles", 32'(nc), 32'd6);
    check("undef_r1", 32'(u_dut.regs[1]), 32'h0);

    // reset while a load is waiting
    clear_rom();
    rom[0] = 16'h5809;
    rom[1] = 16'h6A40;
    rom[2] = 16'hF000;
    wait_cfg   = 1000;
    dmem_rdata = 16'h1234;
    exp_addr   = 9'h040;
    exp_we     = 1'b0;
    do_reset();
    run(12, nc);
    check("mid_req_before", 32'(dmem_req), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_req_drop", 32'(dmem_req), 32'h0);
    check("mid_pc", 32'(imem_addr), 32'h0);
    check("mid_r5", 32'(u_dut.regs[5]), 32'h0);
    check("mid_r4", 32'(u_dut.regs[4]), 32'h0);
    check("mid_halt", 32'(halted), 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("mid_req_hold", 32'(dmem_req), 32'h0);
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
